// File: rtl/mandel_pkg.sv
// Shared types, widths and fixed-point helpers for the escape-time iterator array.
package mandel_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int FRAC        = 28;
  localparam int ITER_W      = 11;
  localparam int COORD_W     = 11;
  // Squares are 2*WORD_LENGTH wide; two extra bits hold the magnitude sum and the doubled cross term.
  localparam int WIDE_W      = 2 * WORD_LENGTH + 2;

  typedef enum logic [1:0] {IDLE, MUL, CHECK, DONE} lane_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [ITER_W-1:0]  depth;
    logic               escaped;
  } result_t;

  // Escape radius squared (4.0) expressed at the scale of a product of two words.
  function automatic logic signed [WIDE_W-1:0] threshold();
    logic signed [WIDE_W-1:0] t;
    t = '0;
    t[2*FRAC+2] = 1'b1;
    return t;
  endfunction

  // Clamp a wide signed value into the signed word range instead of wrapping.
  function automatic logic signed [WORD_LENGTH-1:0] sat_word(input logic signed [WIDE_W-1:0] v);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = {{(WIDE_W-WORD_LENGTH+1){1'b0}}, {(WORD_LENGTH-1){1'b1}}};
    lo = ~hi;
    if (v > hi) begin
      return {1'b0, {(WORD_LENGTH-1){1'b1}}};
    end else if (v < lo) begin
      return {1'b1, {(WORD_LENGTH-1){1'b0}}};
    end else begin
      return v[WORD_LENGTH-1:0];
    end
  endfunction

endpackage

// File: rtl/mandel_lane.sv
// One escape-time iterator: loads a pixel, alternates MUL/CHECK until escape or cap,
// then holds its result in DONE until the output stage acknowledges it.
module mandel_lane
  import mandel_pkg::*;
(
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          ack,
  input  logic [COORD_W-1:0]            ld_x,
  input  logic [COORD_W-1:0]            ld_y,
  input  logic signed [WORD_LENGTH-1:0] ld_zre,
  input  logic signed [WORD_LENGTH-1:0] ld_zim,
  input  logic signed [WORD_LENGTH-1:0] ld_cre,
  input  logic signed [WORD_LENGTH-1:0] ld_cim,
  input  logic [ITER_W-1:0]             ld_max,
  output logic                          idle,
  output logic                          done,
  output result_t                       result
);

  localparam int PROD_W = 2 * WORD_LENGTH;

  lane_state_t                   state_q, state_d;
  logic signed [WORD_LENGTH-1:0] zre_q, zre_d, zim_q, zim_d;
  logic signed [WORD_LENGTH-1:0] cre_q, cre_d, cim_q, cim_d;
  logic signed [PROD_W-1:0]      rr_q, rr_d, ii_q, ii_d, ri_q, ri_d;
  logic [ITER_W-1:0]             depth_q, depth_d, max_q, max_d;
  logic [COORD_W-1:0]            x_q, x_d, y_q, y_d;
  logic                          esc_q, esc_d;

  logic signed [WIDE_W-1:0] rr_w, ii_w, ri_w, cre_w, cim_w;
  logic signed [WIDE_W-1:0] mag_w, re_next_w, im_next_w;
  logic                     escape_now;

  // Widen the registered products and compute the escape test and the next z candidate.
  always_comb begin
    rr_w       = {{(WIDE_W-PROD_W){rr_q[PROD_W-1]}}, rr_q};
    ii_w       = {{(WIDE_W-PROD_W){ii_q[PROD_W-1]}}, ii_q};
    ri_w       = {{(WIDE_W-PROD_W){ri_q[PROD_W-1]}}, ri_q};
    cre_w      = {{(WIDE_W-WORD_LENGTH){cre_q[WORD_LENGTH-1]}}, cre_q};
    cim_w      = {{(WIDE_W-WORD_LENGTH){cim_q[WORD_LENGTH-1]}}, cim_q};
    mag_w      = rr_w + ii_w;
    escape_now = mag_w > threshold();
    re_next_w  = ((rr_w - ii_w) >>> FRAC) + cre_w;
    im_next_w  = ((ri_w <<< 1) >>> FRAC) + cim_w;
  end

  // Next-state and next-data for the lane FSM.
  always_comb begin
    state_d = state_q;
    zre_d   = zre_q;
    zim_d   = zim_q;
    cre_d   = cre_q;
    cim_d   = cim_q;
    rr_d    = rr_q;
    ii_d    = ii_q;
    ri_d    = ri_q;
    depth_d = depth_q;
    max_d   = max_q;
    x_d     = x_q;
    y_d     = y_q;
    esc_d   = esc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          zre_d   = ld_zre;
          zim_d   = ld_zim;
          cre_d   = ld_cre;
          cim_d   = ld_cim;
          max_d   = ld_max;
          x_d     = ld_x;
          y_d     = ld_y;
          depth_d = '0;
          esc_d   = 1'b0;
          state_d = MUL;
        end
      end
      MUL: begin
        rr_d    = PROD_W'(zre_q) * PROD_W'(zre_q);
        ii_d    = PROD_W'(zim_q) * PROD_W'(zim_q);
        ri_d    = PROD_W'(zre_q) * PROD_W'(zim_q);
        state_d = CHECK;
      end
      CHECK: begin
        esc_d = escape_now;
        if (escape_now || (depth_q == max_q)) begin
          state_d = DONE;
        end else begin
          zre_d   = sat_word(re_next_w);
          zim_d   = sat_word(im_next_w);
          depth_d = depth_q + ITER_W'(1);
          state_d = MUL;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane state: the only register that reset has to clear.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Iteration data; only meaningful while the lane is out of IDLE.
  always_ff @(posedge sysclk) begin
    zre_q   <= zre_d;
    zim_q   <= zim_d;
    cre_q   <= cre_d;
    cim_q   <= cim_d;
    rr_q    <= rr_d;
    ii_q    <= ii_d;
    ri_q    <= ri_d;
    depth_q <= depth_d;
    max_q   <= max_d;
    x_q     <= x_d;
    y_q     <= y_d;
    esc_q   <= esc_d;
  end

  assign idle   = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = '{x: x_q, y: y_q, depth: depth_q, escaped: esc_q};

endmodule

// File: rtl/mandel_depth_array.sv
// Array of escape-time lanes: lowest-index idle dispatch on input, round-robin
// collection of finished lanes into a registered valid/ready output.
module mandel_depth_array
  import mandel_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [ITER_W-1:0]             max_iter,
  input  logic                          julia_mode,
  input  logic signed [WORD_LENGTH-1:0] julia_re,
  input  logic signed [WORD_LENGTH-1:0] julia_im,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COORD_W-1:0]            in_x,
  input  logic [COORD_W-1:0]            in_y,
  input  logic signed [WORD_LENGTH-1:0] in_re,
  input  logic signed [WORD_LENGTH-1:0] in_im,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COORD_W-1:0]            out_x,
  output logic [COORD_W-1:0]            out_y,
  output logic [ITER_W-1:0]             out_depth,
  output logic                          out_escaped,
  output logic                          busy
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0] idle_vec, done_vec, start_vec, ack_vec, cand_vec;
  result_t              lane_res [NUM_LANES];

  logic signed [WORD_LENGTH-1:0] ld_zre, ld_zim, ld_cre, ld_cim;

  logic              out_valid_q, out_valid_d;
  result_t           out_res_q, out_res_d;
  logic [LANE_W-1:0] out_lane_q, out_lane_d;
  logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [LANE_W-1:0] gnt_idx;
  logic              gnt_found, out_hs, out_load;

  // Julia mode swaps which of pixel / constant seeds z and which drives c.
  assign ld_zre = julia_mode ? in_re    : '0;
  assign ld_zim = julia_mode ? in_im    : '0;
  assign ld_cre = julia_mode ? julia_re : in_re;
  assign ld_cim = julia_mode ? julia_im : in_im;

  assign in_ready = |idle_vec;
  assign busy     = ~&idle_vec;
  assign out_hs   = out_valid_q && out_ready;

  // Dispatch an accepted pixel to the lowest-index idle lane.
  always_comb begin
    logic found;
    start_vec = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (idle_vec[i] && !found) begin
        start_vec[i] = in_valid;
        found        = 1'b1;
      end
    end
  end

  // A finished lane already sitting in the output register is not offered again;
  // only that lane is released when the output handshakes.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      cand_vec[i] = done_vec[i] && !(out_valid_q && (out_lane_q == LANE_W'(i)));
      ack_vec[i]  = out_hs && (out_lane_q == LANE_W'(i));
    end
  end

  // Round-robin search starting at the pointer.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_LANES;
      if (!gnt_found && cand_vec[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = LANE_W'(idx);
      end
    end
  end

  // Output register: refill when empty or being drained, hold otherwise.
  always_comb begin
    out_load    = gnt_found && (!out_valid_q || out_ready);
    out_valid_d = out_valid_q && !out_ready;
    out_res_d   = out_res_q;
    out_lane_d  = out_lane_q;
    rr_ptr_d    = rr_ptr_q;
    if (out_load) begin
      out_valid_d = 1'b1;
      out_res_d   = lane_res[gnt_idx];
      out_lane_d  = gnt_idx;
      rr_ptr_d    = (gnt_idx == LANE_W'(NUM_LANES - 1)) ? '0 : gnt_idx + LANE_W'(1);
    end
  end

  // Output stage state, cleared by reset so no stale result survives it.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_lane_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_lane_q  <= out_lane_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_x       = out_res_q.x;
  assign out_y       = out_res_q.y;
  assign out_depth   = out_res_q.depth;
  assign out_escaped = out_res_q.escaped;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mandel_lane u_lane (
      .sysclk (sysclk),
      .reset  (reset),
      .start  (start_vec[g]),
      .ack    (ack_vec[g]),
      .ld_x   (in_x),
      .ld_y   (in_y),
      .ld_zre (ld_zre),
      .ld_zim (ld_zim),
      .ld_cre (ld_cre),
      .ld_cim (ld_cim),
      .ld_max (max_iter),
      .idle   (idle_vec[g]),
      .done   (done_vec[g]),
      .result (lane_res[g])
    );
  end

endmodule

// File: tb/tb_mandel_depth_array.sv
// Bench for mandel_depth_array: directed table, multi-cycle corner sequences and
// randomized pixels scored against an arithmetic escape-time model.
module tb_mandel_depth_array;
  import mandel_pkg::*;

  localparam int NL = 4;
  localparam logic signed [31:0] ONE   = 32'sh1000_0000;
  localparam logic signed [31:0] TWO   = 32'sh2000_0000;
  localparam logic signed [31:0] THREE = 32'sh3000_0000;
  localparam logic signed [31:0] HALF  = 32'sh0800_0000;
  localparam logic signed [31:0] MTWO  = 32'shE000_0000;
  localparam logic signed [31:0] P79   = 32'sh7E66_6666;

  logic                          sysclk = 1'b0;
  logic                          reset = 1'b1;
  logic [ITER_W-1:0]             max_iter = '0;
  logic                          julia_mode = 1'b0;
  logic signed [WORD_LENGTH-1:0] julia_re = '0, julia_im = '0;
  logic                          in_valid = 1'b0;
  logic                          in_ready;
  logic [COORD_W-1:0]            in_x = '0, in_y = '0;
  logic signed [WORD_LENGTH-1:0] in_re = '0, in_im = '0;
  logic                          out_valid;
  logic                          out_ready = 1'b1;
  logic [COORD_W-1:0]            out_x, out_y;
  logic [ITER_W-1:0]             out_depth;
  logic                          out_escaped;
  logic                          busy;

  always #5 sysclk = ~sysclk;

  mandel_depth_array #(.NUM_LANES(NL)) dut (
    .sysclk(sysclk), .reset(reset), .max_iter(max_iter), .julia_mode(julia_mode),
    .julia_re(julia_re), .julia_im(julia_im), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_re(in_re), .in_im(in_im), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_depth(out_depth),
    .out_escaped(out_escaped), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  int exp_d [int];
  bit exp_e [int];
  int order_q [$];

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Escape-time reference: iterate z <- z^2 + c on exact integers, clamp each part.
  task automatic model(input bit jm, input logic signed [31:0] pre, pim, jre, jim,
                       input int maxit, output int d, output bit e);
    logic signed [127:0] zr, zi, cr, ci, mag, lim, hi, lo;
    lim = 128'sd1 <<< 58;
    hi  = 128'sd2147483647;
    lo  = -128'sd2147483648;
    zr  = jm ? 128'(pre) : 128'sd0;
    zi  = jm ? 128'(pim) : 128'sd0;
    cr  = jm ? 128'(jre) : 128'(pre);
    ci  = jm ? 128'(jim) : 128'(pim);
    d = 0;
    e = 1'b0;
    while (1'b1) begin
      logic signed [127:0] nr, ni;
      mag = zr * zr + zi * zi;
      if (mag > lim) begin
        e = 1'b1;
        break;
      end
      if (d == maxit) break;
      nr = ((zr * zr - zi * zi) >>> 28) + cr;
      ni = ((zr * zi * 2) >>> 28) + ci;
      zr = (nr > hi) ? hi : (nr < lo) ? lo : nr;
      zi = (ni > hi) ? hi : (ni < lo) ? lo : ni;
      d++;
    end
  endtask

  // Result monitor: scoreboard lookup on handshake, stability check while stalled.
  bit hold_pend = 1'b0;
  logic [COORD_W*2+ITER_W:0] hold_val;
  always @(negedge sysclk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data", 64'({out_x, out_y, out_depth, out_escaped}), 64'(hold_val));
        hold_pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        int key;
        key = int'({out_y, out_x});
        order_q.push_back(key);
        if (exp_d.exists(key)) begin
          chk($sformatf("depth_tag%0d", key), 64'(out_depth), 64'(exp_d[key]));
          chk($sformatf("escaped_tag%0d", key), 64'(out_escaped), 64'(exp_e[key]));
          exp_d.delete(key);
          exp_e.delete(key);
        end else begin
          checks++;
          errors++;
          $display("FAIL unexpected_tag: got tag %0d, expected no result", key);
        end
      end else if (out_valid) begin
        hold_pend = 1'b1;
        hold_val  = {out_x, out_y, out_depth, out_escaped};
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic add_exp(input int tag, input int d, input bit e);
    exp_d[tag] = d;
    exp_e[tag] = e;
  endtask

  task automatic send(input bit jm, input logic signed [31:0] re, im, jr, ji,
                      input int mi, input int tag);
    bit ok;
    julia_mode = jm;
    in_re      = re;
    in_im      = im;
    julia_re   = jr;
    julia_im   = ji;
    max_iter   = ITER_W'(mi);
    in_x       = COORD_W'(tag);
    in_y       = COORD_W'(tag >>> COORD_W);
    in_valid   = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge sysclk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk($sformatf("accept_timeout_tag%0d", tag), 64'(0), 64'(1));
  endtask

  task automatic wait_drain(input int bound);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < bound && !ok; k++) begin
      tick();
      ok = (exp_d.num() == 0) && !out_valid;
    end
    if (!ok) chk("drain_timeout", 64'(exp_d.num()), 64'(0));
  endtask

  typedef struct {
    bit                 julia;
    logic signed [31:0] re, im, jre, jim;
    int                 maxit;
    int                 depth;
    bit                 esc;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int acc, d, tag;
    bit e, got;

    tbl[0] = '{1'b0, TWO,   32'sd0, 32'sd0, 32'sd0, 100, 2,  1'b1};
    tbl[1] = '{1'b0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 20, 20, 1'b0};
    tbl[2] = '{1'b0, MTWO,  32'sd0, 32'sd0, 32'sd0, 15,  15, 1'b0};
    tbl[3] = '{1'b1, THREE, 32'sd0, 32'sd0, 32'sd0, 50,  0,  1'b1};
    tbl[4] = '{1'b1, HALF,  32'sd0, 32'sd0, 32'sd0, 10,  10, 1'b0};
    tbl[5] = '{1'b0, P79,   P79,    32'sd0, 32'sd0, 100, 1,  1'b1};
    tbl[6] = '{1'b0, THREE, 32'sd0, 32'sd0, 32'sd0, 0,   0,  1'b0};
    tbl[7] = '{1'b1, THREE, 32'sd0, 32'sd0, 32'sd0, 0,   0,  1'b1};
    tbl[8] = '{1'b1, TWO,   32'sd0, P79,    32'sd0, 5,   1,  1'b1};
    tbl[9] = '{1'b0, 32'sd0, ONE,   32'sd0, 32'sd0, 30,  30, 1'b0};

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_data", 64'({out_x, out_y, out_depth, out_escaped}), 64'(0));

    // Directed table: result and latency 2d+3; ports scrambled after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tag = 100 + i;
      add_exp(tag, tbl[i].depth, tbl[i].esc);
      send(tbl[i].julia, tbl[i].re, tbl[i].im, tbl[i].jre, tbl[i].jim, tbl[i].maxit, tag);
      acc        = cyc;
      max_iter   = ITER_W'(3);
      julia_mode = ~tbl[i].julia;
      in_re      = 32'sh7FFF_FFFF;
      julia_re   = ONE;
      got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
        @(negedge sysclk);
        if (out_valid) got = 1'b1;
        else tick();
      end
      chk($sformatf("latency_vec%0d", i), 64'(got ? cyc - acc : -1), 64'(2 * tbl[i].depth + 3));
      wait_drain(100);
    end

    // Fill all lanes with output stalled, then release and check order.
    order_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i <= NL; i++) add_exp(200 + i, 50, 1'b0);
    for (int i = 0; i < NL; i++) send(1'b0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 50, 200 + i);
    in_x = COORD_W'(200 + NL);
    in_valid = 1'b1;
    @(negedge sysclk);
    chk("in_ready_full", 64'(in_ready), 64'(0));
    chk("busy_full", 64'(busy), 64'(1));
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      tick();
      got = out_valid;
    end
    chk("stall_valid", 64'(got), 64'(1));
    chk("stall_first_tag", 64'(out_x), 64'(200));
    repeat (8) tick();
    chk("stall_hold_tag", 64'(out_x), 64'(200));
    chk("stall_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    send(1'b0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 50, 200 + NL);
    wait_drain(400);
    chk("order_count", 64'(order_q.size()), 64'(NL + 1));
    for (int i = 0; i < order_q.size() && i <= NL; i++)
      chk($sformatf("order_%0d", i), 64'(order_q[i]), 64'(200 + i));

    // Reset with three lanes busy discards everything.
    for (int i = 0; i < 3; i++) begin
      add_exp(300 + i, 200, 1'b0);
      send(1'b0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 200, 300 + i);
    end
    repeat (5) tick();
    reset = 1'b1;
    tick();
    @(negedge sysclk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    exp_d.delete();
    exp_e.delete();
    reset = 1'b0;
    repeat (450) tick();
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));

    // Randomized pixels against the model with random back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic signed [31:0] re, im, jr, ji;
      bit jm;
      int mi;
      jm = bit'($urandom_range(0, 1));
      re = ($urandom_range(0, 7) == 0) ? $urandom : $signed(32'($urandom_range(0, 1342177280))) - 32'sd671088640;
      im = ($urandom_range(0, 7) == 0) ? $urandom : $signed(32'($urandom_range(0, 1342177280))) - 32'sd671088640;
      jr = $signed(32'($urandom_range(0, 536870912))) - 32'sd268435456;
      ji = $signed(32'($urandom_range(0, 536870912))) - 32'sd268435456;
      mi = int'($urandom_range(0, 40));
      model(jm, re, im, jr, ji, mi, d, e);
      add_exp(400 + i, d, e);
      send(jm, re, im, jr, ji, mi, 400 + i);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_drain(6000);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("final_in_ready", 64'(in_ready), 64'(1));
    chk("final_busy", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
